ysyx_22050078_mem_arbiter: RTL and testbench
============================================

Name: ysyx_22050078_mem_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch requester (read-only) and the load/store requester (read/write).
- Accepts one request at a time, drives it to memory with a valid/ready handshake, waits for the response, and routes the response back to the owning requester.
- Round-robin grant on simultaneous requests.
- A response timeout flags a hung memory and releases the port.

Parameters:
ADDR_WIDTH, 64, address width of requesters and memory port
DATA_WIDTH, 64, data width (fetch data carries the instruction in bits [31:0])
TIMEOUT_CYCLES, 255, max cycles spent in WAIT_RSP before abort; must be at least 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  ADDR_WIDTH  fetch address (pc)
if_rsp_valid  out  1  fetch data valid, 1-cycle pulse
if_rsp_data  out  DATA_WIDTH  fetch data
ls_req_valid  in  1  load/store request
ls_req_ready  out  1  load/store request accepted this cycle
ls_addr  in  ADDR_WIDTH  load/store address
ls_wen  in  1  1 = write, 0 = read
ls_wdata  in  DATA_WIDTH  write data
ls_wmask  in  DATA_WIDTH/8  byte write mask
ls_rsp_valid  out  1  load/store completion, 1-cycle pulse
ls_rsp_data  out  DATA_WIDTH  read data; 0 for writes
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_WIDTH  captured address
mem_wen  out  1  captured write enable (0 for fetch)
mem_wdata  out  DATA_WIDTH  captured write data
mem_wmask  out  DATA_WIDTH/8  captured mask (0 for fetch)
mem_rsp_valid  in  1  memory response valid
mem_rsp_data  in  DATA_WIDTH  memory response data
timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, owner=IF, last_grant=LS, timeout counter=0.
  - All outputs 0, including timeout_err and all data/address outputs.
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - if_req_ready/ls_req_ready are combinational and asserted only in IDLE, for the granted requester only.
  - Grant when only one requester is valid: that requester.
  - Grant when both are valid: the one not equal to last_grant.
  - On a grant: capture addr/wen/wdata/wmask (fetch forces wen=0, wmask=0), set owner, update last_grant, go to ISSUE next cycle.
- ISSUE:
  - mem_req_valid=1 with the captured fields held stable.
  - On mem_req_ready=1: go to WAIT_RSP and clear the counter.
  - No timeout in ISSUE.
- WAIT_RSP:
  - mem_req_valid=0; the counter increments each cycle.
  - On mem_rsp_valid=1: register the data into the owner's rsp_data, pulse the owner's rsp_valid for exactly 1 cycle (the cycle after mem_rsp_valid), go to IDLE.
  - For a write, ls_rsp_data=0 regardless of mem_rsp_data.
  - If the counter reaches TIMEOUT_CYCLES with no response: set timeout_err=1 (sticky until reset), pulse the owner's rsp_valid with data 0, go to IDLE.
  - If mem_rsp_valid and the timeout occur in the same cycle, the response wins and timeout_err is not set.
- rsp_data outputs hold their last value between pulses.
- mem_rsp_valid outside WAIT_RSP is ignored.
- Minimum latency: accept (cycle 0), mem_req_valid (cycle 1), mem_rsp_valid (cycle 2 at earliest), owner rsp_valid (cycle 3). Next grant is possible in cycle 3.
- Requester inputs are sampled only at accept; later changes have no effect on the in-flight transaction.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight transaction is dropped with no rsp pulse.

Test Plan:
- Single fetch, if_addr=0x80000000, mem_req_ready=1, response 0x00000413 one cycle after issue -> if_req_ready in cycle 0, mem_addr=0x80000000 with mem_wen=0 in cycle 1, if_rsp_valid=1 with data 0x00000413 in cycle 3, ls_rsp_valid stays 0.
- Both requesters valid every cycle from reset, if_addr=0x80000000, ls_addr=0x80001000 -> grants alternate IF, LS, IF, LS; each rsp pulse goes only to its owner.
- Store ls_addr=0x80002000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready held low 4 cycles -> mem_req_valid and captured fields stable for all 5 ISSUE cycles; ls_rsp_valid pulses with ls_rsp_data=0.
- TIMEOUT_CYCLES=8, fetch issued, memory never responds -> if_rsp_valid pulses with data 0 after 8 WAIT_RSP cycles, timeout_err=1 and stays 1; next request is serviced normally.
- mem_rsp_valid pulsed while IDLE, then rst_n pulled low during WAIT_RSP of a load -> stray response ignored; after reset all outputs are 0, no ls_rsp_valid, and the first tie goes to IF.

Source files
------------

// File: rtl/ysyx_22050078_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050078_mem_arbiter
// Description : Two-requester (fetch / load-store) arbiter for a single
//               memory port. One transaction in flight at a time, round-robin
//               on ties, response timeout with a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050078_mem_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // instruction fetch requester
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,
  // load/store requester
  input  logic                    ls_req_valid,
  output logic                    ls_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic                    ls_wen,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_wmask,
  output logic                    ls_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ls_rsp_data,
  // memory port
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic                    timeout_err
);

  // Counter must be able to represent TIMEOUT_CYCLES-1 (and stay >= 1 bit).
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t           state;
  logic             owner;       // 0 = fetch, 1 = load/store
  logic             last_grant;  // 0 = fetch, 1 = load/store
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_if;
  logic             grant_ls;
  logic [DATA_WIDTH-1:0] rsp_payload;

  // Round-robin: a lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant_if = if_req_valid && (!ls_req_valid || last_grant);
    grant_ls = ls_req_valid && (!if_req_valid || !last_grant);
  end

  assign if_req_ready = (state == IDLE) && grant_if;
  assign ls_req_ready = (state == IDLE) && grant_ls;

  // Writes complete with zero data; reads return what memory supplied.
  assign rsp_payload = mem_wen ? '0 : mem_rsp_data;

  // Transaction sequencer: capture in IDLE, handshake in ISSUE, collect or time out in WAIT_RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      wait_cnt      <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      if_rsp_valid  <= 1'b0;
      if_rsp_data   <= '0;
      ls_rsp_valid  <= 1'b0;
      ls_rsp_data   <= '0;
      timeout_err   <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if || grant_ls) begin
            owner         <= grant_ls;
            last_grant    <= grant_ls;
            // Fetches are reads: write enable, data and mask all forced to zero.
            mem_addr      <= grant_ls ? ls_addr : if_addr;
            mem_wen       <= grant_ls && ls_wen;
            mem_wdata     <= grant_ls ? ls_wdata : '0;
            mem_wmask     <= grant_ls ? ls_wmask : '0;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            wait_cnt      <= '0;
            state         <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A response arriving on the final allowed cycle beats the timeout.
          if (mem_rsp_valid) begin
            if (owner) begin
              ls_rsp_valid <= 1'b1;
              ls_rsp_data  <= rsp_payload;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rsp_data;
            end
            state <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            if (owner) begin
              ls_rsp_valid <= 1'b1;
              ls_rsp_data  <= '0;
            end else begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= '0;
            end
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050078_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22050078_mem_arbiter
// Description : Self-checking bench: transaction-level reference model,
//               per-cycle compare process, directed scenarios with literal
//               expectations, then randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050078_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rsp_data;
  logic [7:0]    ls_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rsp_data;
  logic [7:0]    mem_wmask;
  logic          timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_22050078_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // m_busy: a transaction is owned; m_issued: memory has accepted it;
  // m_waited: cycles spent waiting for the response so far.
  logic          m_busy, m_issued, m_who, m_last, m_to;
  int            m_waited;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata, m_if_d, m_ls_d;
  logic [7:0]    m_wmask;
  logic          m_if_v, m_ls_v;
  logic          g_if, g_ls;

  assign g_if = if_req_valid && (!ls_req_valid || m_last);
  assign g_ls = ls_req_valid && (!if_req_valid || !m_last);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_issued <= 0; m_who <= 0; m_last <= 1; m_to <= 0; m_waited <= 0;
      m_addr <= 0; m_wen <= 0; m_wdata <= 0; m_wmask <= 0;
      m_if_v <= 0; m_ls_v <= 0; m_if_d <= 0; m_ls_d <= 0;
    end else begin
      m_if_v <= 0;
      m_ls_v <= 0;
      if (!m_busy) begin
        if (g_if || g_ls) begin
          m_busy <= 1; m_issued <= 0; m_who <= g_ls; m_last <= g_ls;
          m_addr  <= g_ls ? ls_addr : if_addr;
          m_wen   <= g_ls ? ls_wen : 1'b0;
          m_wdata <= g_ls ? ls_wdata : '0;
          m_wmask <= g_ls ? ls_wmask : '0;
        end
      end else if (!m_issued) begin
        if (mem_req_ready) begin m_issued <= 1; m_waited <= 0; end
      end else if (mem_rsp_valid) begin
        m_busy <= 0;
        if (m_who) begin m_ls_v <= 1; m_ls_d <= m_wen ? '0 : mem_rsp_data; end
        else       begin m_if_v <= 1; m_if_d <= mem_rsp_data; end
      end else if (m_waited + 1 == TO) begin
        m_busy <= 0; m_to <= 1;
        if (m_who) begin m_ls_v <= 1; m_ls_d <= '0; end
        else       begin m_if_v <= 1; m_if_d <= '0; end
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  // Compare every output against the model once per cycle, after inputs settle.
  always begin
    @(negedge clk);
    #1;
    chk("if_req_ready",  if_req_ready,  !m_busy && g_if);
    chk("ls_req_ready",  ls_req_ready,  !m_busy && g_ls);
    chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
    chk("mem_addr",      mem_addr,      m_addr);
    chk("mem_wen",       mem_wen,       m_wen);
    chk("mem_wdata",     mem_wdata,     m_wdata);
    chk("mem_wmask",     mem_wmask,     m_wmask);
    chk("if_rsp_valid",  if_rsp_valid,  m_if_v);
    chk("if_rsp_data",   if_rsp_data,   m_if_d);
    chk("ls_rsp_valid",  ls_rsp_valid,  m_ls_v);
    chk("ls_rsp_data",   ls_rsp_data,   m_ls_d);
    chk("timeout_err",   timeout_err,   m_to);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req_valid = 0; if_addr = 0;
    ls_req_valid = 0; ls_addr = 0; ls_wen = 0; ls_wdata = 0; ls_wmask = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    do_reset();
    #2;
    chk("lit_reset_timeout", timeout_err, 0);
    chk("lit_reset_memv", mem_req_valid, 0);
    chk("lit_reset_addr", mem_addr, 0);

    // Single fetch with minimum latency.
    cyc(); if_req_valid = 1; if_addr = 64'h8000_0000; mem_req_ready = 1; #2;
    chk("lit_fetch_ready_c0", if_req_ready, 1);
    cyc(); if_req_valid = 0; if_addr = 64'h1234; #2;
    chk("lit_fetch_memv_c1", mem_req_valid, 1);
    chk("lit_fetch_addr_c1", mem_addr, 64'h8000_0000);
    chk("lit_fetch_wen_c1", mem_wen, 0);
    cyc(); mem_rsp_valid = 1; mem_rsp_data = 64'h413; #2;
    chk("lit_fetch_memv_c2", mem_req_valid, 0);
    cyc(); mem_rsp_valid = 0; #2;
    chk("lit_fetch_rspv_c3", if_rsp_valid, 1);
    chk("lit_fetch_rspd_c3", if_rsp_data, 64'h413);
    chk("lit_fetch_ls_quiet", ls_rsp_valid, 0);
    cyc(); #2;
    chk("lit_fetch_rsp_pulse", if_rsp_valid, 0);
    chk("lit_fetch_rsp_hold", if_rsp_data, 64'h413);

    // Both requesters valid from reset: grants alternate IF, LS, IF, LS.
    do_reset();
    if_req_valid = 1; if_addr = 64'h8000_0000;
    ls_req_valid = 1; ls_addr = 64'h8000_1000;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 64'h1111;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("lit_rr_if_ready", if_req_ready, (k % 2 == 0));
      chk("lit_rr_ls_ready", ls_req_ready, (k % 2 == 1));
      if (k > 0) begin
        chk("lit_rr_if_rsp", if_rsp_valid, ((k - 1) % 2 == 0));
        chk("lit_rr_ls_rsp", ls_rsp_valid, ((k - 1) % 2 == 1));
      end
      cyc(); cyc(); cyc();
    end
    idle_inputs(); #2;
    chk("lit_rr_last_ls_rsp", ls_rsp_valid, 1);
    chk("lit_rr_last_ls_data", ls_rsp_data, 64'h1111);

    // Store held in ISSUE for 5 cycles.
    cyc(); ls_req_valid = 1; ls_wen = 1; ls_addr = 64'h8000_2000;
    ls_wdata = 64'hDEAD_BEEF; ls_wmask = 8'h0F; #2;
    chk("lit_st_ready", ls_req_ready, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(); ls_req_valid = 0; ls_wdata = {$urandom, $urandom}; ls_wmask = 8'hFF;
      mem_req_ready = (i == 4); #2;
      chk("lit_st_memv", mem_req_valid, 1);
      chk("lit_st_addr", mem_addr, 64'h8000_2000);
      chk("lit_st_wdata", mem_wdata, 64'hDEAD_BEEF);
      chk("lit_st_wmask", mem_wmask, 8'h0F);
      chk("lit_st_wen", mem_wen, 1);
    end
    cyc(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'h1234;
    cyc(); mem_rsp_valid = 0; #2;
    chk("lit_st_rspv", ls_rsp_valid, 1);
    chk("lit_st_rspd", ls_rsp_data, 0);

    // Fetch with no response: timeout after TO waiting cycles.
    cyc(); if_req_valid = 1; if_addr = 64'h8000_0004; mem_req_ready = 1;
    cyc(); if_req_valid = 0;
    for (int i = 0; i < TO; i++) cyc();
    #2;
    chk("lit_to_not_yet", if_rsp_valid, 0);
    chk("lit_to_flag_clear", timeout_err, 0);
    cyc(); #2;
    chk("lit_to_rspv", if_rsp_valid, 1);
    chk("lit_to_rspd", if_rsp_data, 0);
    chk("lit_to_flag", timeout_err, 1);
    cyc(); if_req_valid = 1; if_addr = 64'h8000_0008; #2;
    chk("lit_after_to_ready", if_req_ready, 1);
    cyc(); if_req_valid = 0;
    cyc(); mem_rsp_valid = 1; mem_rsp_data = 64'h13;
    cyc(); mem_rsp_valid = 0; #2;
    chk("lit_after_to_rspv", if_rsp_valid, 1);
    chk("lit_after_to_rspd", if_rsp_data, 64'h13);
    chk("lit_to_sticky", timeout_err, 1);

    // Stray response in IDLE, then reset during a load's WAIT_RSP.
    cyc(); mem_rsp_valid = 1; mem_rsp_data = 64'hFF;
    cyc(); mem_rsp_valid = 0; #2;
    chk("lit_stray_if", if_rsp_valid, 0);
    chk("lit_stray_ls", ls_rsp_valid, 0);
    cyc(); ls_req_valid = 1; ls_wen = 0; ls_addr = 64'h8000_3000;
    cyc(); ls_req_valid = 0;
    cyc(); mem_req_ready = 0; #2;
    rst_n = 0; #1;
    chk("lit_rst_to", timeout_err, 0);
    chk("lit_rst_addr", mem_addr, 0);
    chk("lit_rst_lsd", ls_rsp_data, 0);
    chk("lit_rst_ifd", if_rsp_data, 0);
    cyc(); cyc(); rst_n = 1;
    cyc(); mem_rsp_valid = 1; mem_rsp_data = 64'h77; #2;
    chk("lit_rst_no_lsrsp", ls_rsp_valid, 0);
    cyc(); mem_rsp_valid = 0; if_req_valid = 1; ls_req_valid = 1; #2;
    chk("lit_rst_tie_if", if_req_ready, 1);
    chk("lit_rst_tie_ls", ls_req_ready, 0);
    chk("lit_rst_no_lsrsp2", ls_rsp_valid, 0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      cyc();
      if ($urandom_range(0, 599) == 0) rst_n = 0;
      else rst_n = 1;
      if_req_valid  = ($urandom_range(0, 2) == 0);
      if_addr       = {$urandom, $urandom};
      ls_req_valid  = ($urandom_range(0, 2) == 0);
      ls_addr       = {$urandom, $urandom};
      ls_wen        = $urandom_range(0, 1);
      ls_wdata      = {$urandom, $urandom};
      ls_wmask      = 8'($urandom);
      mem_req_ready = ($urandom_range(0, 4) < 3);
      mem_rsp_valid = ($urandom_range(0, 9) < 2);
      mem_rsp_data  = {$urandom, $urandom};
    end
    cyc(); idle_inputs(); rst_n = 1;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
